// File: rtl/if_fetch.sv
// Instruction-fetch stage: gathers a 32-bit instruction one byte per granted
// cycle over the shared byte-wide memory port and hands it to decode.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        jump_i,
   input  logic [31:0] jump_addr_i,
   input  logic        mem_grant_i,
   input  logic [7:0]  mem_din_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        if_valid_o
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] asm_buf;
   logic [31:0] next_buf;
   logic [2:0]  issue_cnt;
   logic [2:0]  recv_cnt;
   logic        pend;
   logic        issue;

   // A redirect suppresses the request in its own cycle so no stale byte is issued.
   assign mem_req_o  = rst && (state == FETCH) && (issue_cnt < 3'd4) && !jump_i;
   assign mem_addr_o = pc + {29'd0, issue_cnt};
   assign issue      = mem_req_o && mem_grant_i;

   // Buffer with the arriving byte merged in, so completion can load the full word.
   always_comb begin
      next_buf = asm_buf;
      next_buf[{recv_cnt[1:0], 3'b000} +: 8] = mem_din_i;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         issue_cnt  <= 3'd0;
         recv_cnt   <= 3'd0;
         pend       <= 1'b0;
         asm_buf    <= 32'd0;
         if_valid_o <= 1'b0;
         if_inst_o  <= 32'd0;
         if_pc_o    <= 32'd0;
      end else if (jump_i) begin
         state      <= FETCH;
         pc         <= jump_addr_i;
         issue_cnt  <= 3'd0;
         recv_cnt   <= 3'd0;
         pend       <= 1'b0;
         if_valid_o <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               pend <= issue;
               if (issue)
                  issue_cnt <= issue_cnt + 3'd1;
               if (pend) begin
                  asm_buf  <= next_buf;
                  recv_cnt <= recv_cnt + 3'd1;
                  if (recv_cnt == 3'd3) begin
                     if_inst_o  <= next_buf;
                     if_pc_o    <= pc;
                     if_valid_o <= 1'b1;
                     state      <= HOLD;
                  end
               end
            end
            HOLD: begin
               pend <= 1'b0;
               if (!stall_i) begin
                  if_valid_o <= 1'b0;
                  pc         <= pc + 32'd4;
                  issue_cnt  <= 3'd0;
                  recv_cnt   <= 3'd0;
                  state      <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: an event-level model predicts request traffic
// and valid timing; a scoreboard checks every delivered pc/instruction.
module tb_if_fetch;

   localparam logic [31:0] RPC = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_i = 1'b0;
   logic        jump_i = 1'b0;
   logic [31:0] jump_addr_i = 32'd0;
   logic        mem_grant_i = 1'b0;
   logic [7:0]  mem_din_i = 8'd0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_valid_o;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i),
      .jump_addr_i(jump_addr_i), .mem_grant_i(mem_grant_i), .mem_din_i(mem_din_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .if_pc_o(if_pc_o),
      .if_inst_o(if_inst_o), .if_valid_o(if_valid_o)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  mem [logic [31:0]];
   exp_t        q[$];

   // Model: target pc, grants so far, completion pending, instruction presented.
   bit          m_known = 0, m_pres = 0, m_fin = 0, m_queued = 0, m_rst_prev = 0;
   logic [31:0] m_tgt = 32'd0;
   int          m_gnt = 0;
   int          n_deliv = 0;
   bit          d_pend = 0;
   logic [31:0] d_addr = 32'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out at %0t", nm, $time);
   endtask

   function automatic logic [7:0] rd(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = 8'($urandom);
      return mem[a];
   endfunction

   function automatic logic [31:0] word(input logic [31:0] a);
      return {rd(a + 32'd3), rd(a + 32'd2), rd(a + 32'd1), rd(a)};
   endfunction

   task automatic new_target(input logic [31:0] a);
      exp_t e;
      if (m_queued) void'(q.pop_back());
      e.pc   = a;
      e.inst = word(a);
      q.push_back(e);
      m_queued = 1;
      m_tgt    = a;
      m_pres   = 0;
      m_gnt    = 0;
      m_fin    = 0;
   endtask

   // One clock cycle: drive at negedge, check and advance the model 1 time unit later.
   task automatic step(input bit r, input bit j, input logic [31:0] ja, input bit g, input bit s);
      bit exp_req;
      @(negedge clk);
      rst = r; jump_i = j; jump_addr_i = ja; mem_grant_i = g; stall_i = s;
      mem_din_i = d_pend ? rd(d_addr) : 8'($urandom);
      #1;
      exp_req = r && !m_pres && (m_gnt < 4) && !j;
      if (m_known) begin
         chk("mem_req", {31'd0, mem_req_o}, {31'd0, exp_req});
         if (exp_req) chk("mem_addr", mem_addr_o, m_tgt + 32'(m_gnt));
         chk("if_valid", {31'd0, if_valid_o}, {31'd0, m_pres});
         if (m_rst_prev) begin
            chk("rst_pc", if_pc_o, 32'd0);
            chk("rst_inst", if_inst_o, 32'd0);
         end
      end
      d_pend     = (mem_req_o === 1'b1) && g;
      d_addr     = mem_addr_o;
      m_rst_prev = !r;
      if (!r) begin
         new_target(RPC);
         m_known = 1;
      end else if (j) begin
         new_target(ja);
      end else if (m_pres) begin
         if (!s) new_target(m_tgt + 32'd4);
      end else if (m_fin) begin
         m_pres   = 1;
         m_fin    = 0;
         m_queued = 0;
         n_deliv++;
      end else if (exp_req && g) begin
         m_gnt++;
         if (m_gnt == 4) m_fin = 1;
      end
   endtask

   task automatic wait_pres(input string nm);
      for (int k = 0; k < 60 && !m_pres; k++) step(1, 0, 32'd0, 1, 1);
      if (!m_pres) timeout(nm);
   endtask

   task automatic wait_gnt(input int n, input string nm);
      for (int k = 0; k < 60 && !(m_gnt == n && !m_pres && !m_fin); k++) step(1, 0, 32'd0, 1, 0);
      if (!(m_gnt == n && !m_pres)) timeout(nm);
   endtask

   // Scoreboard monitor: pops on each new presentation, checks every valid cycle.
   exp_t cur;
   bit   prev_v = 0;
   always @(negedge clk) begin
      if (if_valid_o === 1'b1) begin
         if (!prev_v) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_empty: got valid pc %h expected no instruction", if_pc_o);
            end else begin
               cur = q.pop_front();
            end
         end
         chk("if_pc", if_pc_o, cur.pc);
         chk("if_inst", if_inst_o, cur.inst);
      end
      prev_v = (if_valid_o === 1'b1);
   end

   initial begin
      mem[32'h0] = 8'h93; mem[32'h1] = 8'h00; mem[32'h2] = 8'hA0; mem[32'h3] = 8'h00;
      step(0, 0, 32'd0, 1, 0);
      step(0, 0, 32'd0, 1, 0);
      // Wrap fetch at FFFFFFFC, then consume into pc 0 (00A00093), then reset mid-fetch of pc 4.
      for (int k = 0; k < 60 && n_deliv < 2; k++) step(1, 0, 32'd0, 1, 0);
      if (n_deliv < 2) timeout("wrap_fetch");
      wait_gnt(2, "third_byte");
      step(0, 0, 32'd0, 1, 0);
      // Grant gaps on the 2nd and 3rd request cycles.
      wait_gnt(1, "gap_start");
      step(1, 0, 32'd0, 0, 1);
      step(1, 0, 32'd0, 0, 1);
      wait_pres("gap_fetch");
      // Stall held four cycles, then consumed.
      repeat (4) step(1, 0, 32'd0, 1, 1);
      step(1, 0, 32'd0, 1, 0);
      // Mid-fetch jump right after addr+1 is granted.
      wait_gnt(2, "jump_mid");
      step(1, 1, 32'h100, 1, 1);
      wait_pres("jump_fetch");
      step(1, 0, 32'd0, 1, 0);
      // Jump and consume in the same HOLD cycle: redirect wins.
      wait_pres("hold_fetch");
      step(1, 1, 32'h40, 1, 0);
      wait_pres("jump40_fetch");
      step(1, 0, 32'd0, 1, 0);
      // Cold fetch of the known word at 0.
      step(1, 1, 32'h0, 1, 0);
      wait_pres("zero_fetch");
      step(1, 0, 32'd0, 1, 0);
      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         logic [31:0] ja;
         ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
         step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0, ja,
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end
      repeat (12) step(1, 0, 32'd0, 1, 0);
      if (n_deliv < 10) timeout("deliveries");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage feeding the decode stage. Reads 32-bit instructions over the shared byte-wide memory port, one byte per granted cycle. Assembles the bytes little-endian and presents `pc`/`inst` with a valid/stall handshake. Accepts branch/jump redirects from the execute stage, which abort any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0: pc fetched first after reset.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` edge).
- `stall_i`  in  1  decode not accepting; 1 holds the presented instruction.
- `jump_i`  in  1  redirect request from execute (taken branch, JAL, JALR).
- `jump_addr_i`  in  32  redirect target.
- `mem_grant_i`  in  1  memory arbiter grants the fetch request this cycle.
- `mem_din_i`  in  8  read data, valid the cycle after a granted request.
- `mem_req_o`  out  1  fetch requests the memory port (combinational).
- `mem_addr_o`  out  32  byte address of the request (combinational).
- `if_pc_o`  out  32  pc of the presented instruction (registered).
- `if_inst_o`  out  32  presented instruction (registered).
- `if_valid_o`  out  1  `if_pc_o`/`if_inst_o` valid (registered).

## Operation
- Registers:
  - `pc` (32): address of the instruction being fetched.
  - `issue_cnt` (0..4): bytes requested so far.
  - `recv_cnt` (0..4): bytes received so far.
  - `pend`: a granted request was issued last cycle.
  - `buf` (32): assembly buffer.
- FSM has two states:
  - FETCH: collect 4 bytes for `pc`.
  - HOLD: instruction presented, waiting for decode to accept it.
- FETCH behaviour:
  - `mem_req_o = (issue_cnt < 4) && !jump_i`.
  - `mem_addr_o = pc + issue_cnt`, modulo 2^32.
  - A cycle with `mem_req_o && mem_grant_i` increments `issue_cnt` and sets `pend` for the next cycle; otherwise `pend` is cleared.
  - If `pend` = 1, `mem_din_i` is written to `buf[8*recv_cnt +: 8]` and `recv_cnt` increments.
  - Completion: the edge on which `recv_cnt` becomes 4 loads `if_inst_o` (including the final byte), sets `if_pc_o = pc` and `if_valid_o = 1`, and moves to HOLD.
- HOLD behaviour:
  - `mem_req_o = 0`.
  - Outputs stay stable while `stall_i` = 1.
  - In a cycle with `stall_i` = 0 the instruction is consumed. At that edge: `if_valid_o` → 0, `pc` ← `pc + 4` (wraps at 2^32), counters clear, state → FETCH.
- Redirect (`jump_i` = 1, any state), which has highest priority:
  - The same cycle, `mem_req_o` is forced to 0, so no new byte is issued.
  - At the edge: `pc` ← `jump_addr_i`; `issue_cnt`, `recv_cnt` and `pend` clear; `if_valid_o` → 0; state → FETCH.
  - A byte arriving in the jump cycle is discarded.
  - No alignment check; bytes are fetched at `jump_addr_i + 0..3` as given.
  - A jump in HOLD with `stall_i` = 0 counts as a redirect only. It is not also a consume, so there is no `pc + 4`.
- Reset (`rst` = 0 at an edge), from any state including mid-fetch:
  - `pc = RESET_PC`, state = FETCH, counters 0, `pend` 0, `buf` 0.
  - `if_valid_o = 0`, `if_inst_o = 0`, `if_pc_o = 0`.
  - `mem_req_o` is 0 in any cycle where `rst` = 0.
  - In-flight bytes are dropped.

## Timing
- `mem_grant_i` held 1, first address in cycle N:
  - addresses `pc..pc+3` go out in N..N+3;
  - bytes arrive in N+1..N+4;
  - `if_valid_o` = 1 in N+5.
- Consumed in N+5 → next fetch's first address in N+6. Peak throughput is one instruction per 6 cycles.
- Each cycle with `mem_grant_i` = 0 while requesting delays completion by one cycle. The address is held unchanged until granted.
- After a jump at cycle J, the first target address is issued in J+1.
- After `rst` deasserts, the first request (`RESET_PC`) is issued in the first cycle with `rst` = 1.
- `if_valid_o` never rises in the cycle after a jump or reset.

## Test plan
- Reset → cold fetch:
  - Stimulus: memory[0..3] = 93 00 A0 00; grant always 1; `stall_i` 0.
  - Response: `mem_addr_o` = 0,1,2,3 in cycles 1–4; cycle 6 shows `if_valid_o` = 1, `if_inst_o` = 32'h00A00093, `if_pc_o` = 0; next request is addr 4 in cycle 7.
- Grant gaps:
  - Stimulus: `mem_grant_i` low on the 2nd and 3rd request cycles.
  - Response: addr 1 held for 3 cycles; `if_valid_o` rises 2 cycles later than the no-gap case; instruction value unchanged.
- Stall:
  - Stimulus: `stall_i` = 1 for 4 cycles after `if_valid_o` rises.
  - Response: `if_inst_o`/`if_pc_o` stable, `mem_req_o` = 0; fetch of `pc + 4` starts the cycle after `stall_i` falls.
- Mid-fetch jump:
  - Stimulus: `jump_i` = 1, `jump_addr_i` = 32'h100 in the cycle after addr 1 is granted.
  - Response: `mem_req_o` = 0 that cycle; next addresses are 0x100..0x103; delivered `if_pc_o` = 0x100 with bytes only from 0x100..0x103.
- Jump vs consume:
  - Stimulus: in HOLD, `stall_i` = 0 and `jump_i` = 1 with target 0x40.
  - Response: `if_valid_o` → 0; next fetch at 0x40, not `pc + 4`.
- Wrap and reset:
  - Stimulus: `RESET_PC` = 32'hFFFFFFFC, instruction consumed.
  - Response: next fetch addresses are 0,1,2,3.
  - Stimulus: assert `rst` = 0 during the 3rd byte of that fetch.
  - Response: all outputs return to reset values; fetch restarts at 32'hFFFFFFFC.
